// File: rtl/chacha_word_serializer.sv
// chacha_word_serializer: requests 512-bit keystream blocks from the chacha core,
// buffers one block and streams it out as sixteen 32-bit words, word 0 first.
module chacha_word_serializer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter bit          AUTO_REFILL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [255:0] key_in,
  input  logic         key_load,
  output logic [255:0] core_key,
  output logic         core_valid,
  input  logic         core_intr,
  input  logic [511:0] core_out,
  output logic [31:0]  rnd_data,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic         rnd_last,
  output logic [31:0]  blk_cnt,
  output logic         err_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, WAITLOW} state_t;

  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT_CYC - 1);

  state_t       state;
  logic [511:0] buffer;
  logic [3:0]   idx;
  logic [15:0]  timer;
  logic [255:0] key_pend;
  logic         key_pend_vld;
  logic         enable_q;
  logic         armed;
  logic         retry_idle;
  logic         start_ok;
  logic         xfer;
  logic         req_done;

  // Output handshake: a word moves on any cycle with rnd_valid && rnd_ready;
  // rnd_data and rnd_last stay fixed while rnd_valid is high and rnd_ready is low.
  assign xfer     = rnd_valid && rnd_ready;
  assign rnd_data = buffer[{idx, 5'd0} +: 32];
  assign rnd_last = rnd_valid && (idx == 4'd15);
  assign req_done = core_intr || (timer == TIMER_MAX);
  assign start_ok = enable && !core_intr && (AUTO_REFILL || armed || !enable_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      buffer       <= '0;
      idx          <= '0;
      timer        <= '0;
      key_pend     <= '0;
      key_pend_vld <= 1'b0;
      enable_q     <= 1'b0;
      armed        <= 1'b0;
      retry_idle   <= 1'b0;
      core_key     <= '0;
      core_valid   <= 1'b0;
      rnd_valid    <= 1'b0;
      blk_cnt      <= '0;
      err_timeout  <= 1'b0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) armed <= 1'b1;
      if (key_load) err_timeout <= 1'b0;
      if (key_load && state != REQ) core_key <= key_in;

      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= REQ;
            core_valid <= 1'b1;
            timer      <= '0;
            armed      <= 1'b0;
          end
        end
        REQ: begin
          // core_key is frozen while the request is open; loads wait in key_pend.
          if (key_load) begin
            key_pend     <= key_in;
            key_pend_vld <= 1'b1;
          end
          if (req_done) begin
            core_valid   <= 1'b0;
            key_pend_vld <= 1'b0;
            if (key_load) core_key <= key_in;
            else if (key_pend_vld) core_key <= key_pend;
          end
          if (core_intr) begin
            buffer    <= core_out;
            blk_cnt   <= blk_cnt + 32'd1;
            idx       <= '0;
            rnd_valid <= 1'b1;
            state     <= DRAIN;
          end else if (timer == TIMER_MAX) begin
            err_timeout <= 1'b1;
            retry_idle  <= 1'b1;
            state       <= WAITLOW;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DRAIN: begin
          if (xfer) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              rnd_valid <= 1'b0;
              state     <= WAITLOW;
            end
          end
        end
        WAITLOW: begin
          // After a timeout the retry goes through IDLE rather than straight back to REQ.
          if (!core_intr) begin
            retry_idle <= 1'b0;
            if (enable && AUTO_REFILL && !retry_idle) begin
              state      <= REQ;
              core_valid <= 1'b1;
              timer      <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
